cnt_cmd_sequencer: RTL
======================

Name: cnt_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the 8-bit up/down counter and drives its en/set/up/load-value controls.
- Accepts one command at a time over a valid/ready handshake: LOAD a value, COUNT UP N steps, COUNT DOWN N steps, or NOP.
- Converts each command into a cycle-exact control sequence, then pulses done_out.
- Optionally takes the counter's overflow flag back to abort a count early.

Parameters:
- WIDTH, 8, width of counter value and step count.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- cmd_valid_in  input  1  command present.
- cmd_ready_out  output  1  sequencer can accept a command.
- cmd_op_in  input  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 NOP.
- cmd_arg_in  input  WIDTH  LOAD value, or step count N for UP/DOWN.
- ovf_in  input  1  overflow flag from the counter.
- en_ctrl_out  output  1  counter enable.
- set_ctrl_out  output  1  counter synchronous load.
- up_ctrl_out  output  1  count direction, 1 = up.
- counter_val_out  output  WIDTH  load value presented to the counter.
- busy_out  output  1  command in progress.
- done_out  output  1  one-cycle completion pulse.
- err_out  output  1  count aborted on overflow; valid only with done_out.

Behaviour:
- Reset (rst_in=0, async, immediate):
  - State IDLE; cmd_ready_out=1.
  - en_ctrl_out, set_ctrl_out, up_ctrl_out, busy_out, done_out, err_out = 0.
  - counter_val_out=0; internal remaining-step count = 0.
  - Reset mid-command discards the command; no done_out is produced for it.
- All outputs are registered.
- Handshake:
  - Accept occurs at a rising edge with cmd_valid_in=1 and cmd_ready_out=1.
  - cmd_ready_out=1 only in IDLE; busy_out = NOT cmd_ready_out.
  - cmd_valid_in while not ready is ignored; nothing is latched.
  - op and arg are captured at the accept edge; later changes have no effect.
- States: IDLE, LOAD, RUN, DONE.
- Cycle timing, with accept at edge k:
  - LOAD:
    - IDLE->LOAD; set_ctrl_out=1 for one cycle, edges k to k+1.
    - counter_val_out=arg from edge k, held until the next LOAD.
    - LOAD->DONE at k+1; done_out=1 during k+1 to k+2; IDLE and ready=1 at k+2.
  - UP/DOWN with N>0:
    - IDLE->RUN; en_ctrl_out=1 for exactly N consecutive cycles, edges k to k+N.
    - up_ctrl_out=1 (UP) or 0 (DOWN) for the same N cycles, otherwise 0.
    - RUN->DONE at k+N; done_out=1 during k+N to k+N+1; ready=1 at k+N+1.
  - UP/DOWN with N=0, and NOP:
    - IDLE->DONE directly; no en/set activity.
    - done_out=1 during k to k+1; ready=1 at k+1.
  - DONE->IDLE is unconditional.
- Invariants:
  - en_ctrl_out and set_ctrl_out are never 1 together; the counter honours set only when en=0.
  - The minimum back-to-back command spacing follows from DONE+IDLE. A command is accepted only on an edge where ready=1.
- Width rules: N ranges 0..2^WIDTH-1, so at most 255 steps at the default. The remaining count is WIDTH bits and decrements once per RUN cycle; it never wraps.
- ovf_in is ignored outside RUN in all builds.

Optional Feature:
- Macro: CNT_SEQ_OVF_ABORT_EN.
- Defined:
  - ovf_in is sampled at each rising edge while in RUN.
  - If ovf_in=1, RUN->DONE at that edge regardless of the remaining count, and en_ctrl_out drops at that edge.
  - err_out=1 together with done_out for one cycle.
  - If ovf_in=1 on the same edge RUN would end anyway, err_out=1 still.
- Not defined: ovf_in unused; err_out tied to 0.

Test Plan:
- Reset check: hold rst_in=0, then release -> ready=1, all other outputs 0, counter_val_out=0. Assert rst_in=0 mid-RUN -> en_ctrl_out=0 immediately; no done_out follows.
- LOAD 8'hA5 -> set_ctrl_out=1 for exactly 1 cycle with counter_val_out=8'hA5 and en=0; done_out 1 cycle later; ready returns 2 cycles after accept.
- UP N=5 -> en=1 and up=1 for exactly 5 cycles; done_out on cycle 6; counter advances 5. Follow with DOWN N=3 -> en=1, up=0 for 3 cycles.
- UP N=0 and NOP -> no en/set pulses; done_out in the cycle after accept. Hold cmd_valid_in=1 while busy during UP N=4 -> only one command accepted, and the held command is accepted exactly when ready=1.
- Macro defined: LOAD 8'hFB, then UP N=10 -> ovf_in rises and the sequence aborts; en drops; done_out=1 with err_out=1. Macro undefined: full 10 en cycles, err_out=0.
- Randomised op/arg stream with a reference model -> en and set never both 1; every accepted command yields exactly one done_out; en-cycle count equals N.

Source files
------------

// File: rtl/cnt_cmd_sequencer.sv
// Command front-end for the up/down counter: turns LOAD/UP/DOWN/NOP commands into en/set/up sequences.
// Define CNT_SEQ_OVF_ABORT_EN to let the counter's overflow flag abort a count with err_out.
module cnt_cmd_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [1:0]       cmd_op_in,
  input  logic [WIDTH-1:0] cmd_arg_in,
  input  logic             ovf_in,
  output logic             en_ctrl_out,
  output logic             set_ctrl_out,
  output logic             up_ctrl_out,
  output logic [WIDTH-1:0] counter_val_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             set_q, set_d;
  logic             up_q, up_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovf_abort;

`ifdef CNT_SEQ_OVF_ABORT_EN
  assign ovf_abort = ovf_in;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_in;
  assign ovf_abort  = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    val_d   = val_q;
    ready_d = 1'b0;
    en_d    = 1'b0;
    set_d   = 1'b0;
    up_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid_in && ready_q) begin
          ready_d = 1'b0;
          unique case (op_e'(cmd_op_in))
            OP_LOAD: begin
              state_d = S_LOAD;
              set_d   = 1'b1;
              val_d   = cmd_arg_in;
            end
            OP_UP, OP_DOWN: begin
              if (cmd_arg_in != '0) begin
                state_d = S_RUN;
                en_d    = 1'b1;
                up_d    = (op_e'(cmd_op_in) == OP_UP);
                rem_d   = cmd_arg_in;
              end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
            default: begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_RUN: begin
        // rem_q counts the enable cycles still owed, including the current one.
        rem_d = rem_q - WIDTH'(1);
        if (ovf_abort || rem_q == WIDTH'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = ovf_abort;
          rem_d   = '0;
        end else begin
          en_d = 1'b1;
          up_d = up_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase

    busy_d = ~ready_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      val_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      set_q   <= 1'b0;
      up_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      set_q   <= set_d;
      up_q    <= up_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_out   = ready_q;
  assign busy_out        = busy_q;
  assign en_ctrl_out     = en_q;
  assign set_ctrl_out    = set_q;
  assign up_ctrl_out     = up_q;
  assign counter_val_out = val_q;
  assign done_out        = done_q;
  assign err_out         = err_q;

endmodule
